// File: rtl/ps2_key_sequencer.sv
// PS/2 Set-2 key sequencer: folds E0/F0/E1 prefix sequences from the byte
// receiver into single key events, queues them in a show-ahead FIFO and
// aborts stalled receiver frames or stale prefix sequences via a watchdog.
//
// Output handshake: key_valid is high whenever the FIFO holds an event and
// {key_extended, key_released, key_code} then describe the head event; the
// event is consumed on a rising clk edge where key_valid && key_ready, and
// the head fields stay stable while key_valid=1 and key_ready=0.
module ps2_key_sequencer #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strb,
  input  logic       rx_active,
  output logic       rx_abort,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE_SKIP
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      skip, skip_nx;
  logic [WD_W-1:0] wd, wd_nx;
  logic            abort_nx;
  logic            push;
  logic [9:0]      push_data;
  logic            is_prefix, is_discard, is_plain;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count, count_nx;
  logic             pop, full, do_push, drop;
  logic [9:0]       head_nx;

  // Byte classification: prefixes start sequences, the discard set carries
  // keyboard status/ack codes that never form key events.
  always_comb begin
    is_prefix  = (rx_data == 8'hE0) || (rx_data == 8'hE1) || (rx_data == 8'hF0);
    is_discard = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                 (rx_data == 8'hFA) || (rx_data == 8'hFC) || (rx_data == 8'hFE) ||
                 (rx_data == 8'hFF);
    is_plain   = !is_prefix && !is_discard;
  end

  // Sequencer next state, event generation and watchdog; a strobe always
  // takes priority over watchdog expiry.
  always_comb begin
    state_nx  = state;
    skip_nx   = skip;
    wd_nx     = wd;
    abort_nx  = 1'b0;
    push      = 1'b0;
    push_data = {2'b00, rx_data};
    if (rx_strb) begin
      wd_nx = '0;
      case (state)
        S_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nx = S_EXT;
          end else if (rx_data == 8'hF0) begin
            state_nx = S_BRK;
          end else if (rx_data == 8'hE1) begin
            state_nx = S_PAUSE_SKIP;
            skip_nx  = 3'd7;
          end else if (!is_discard) begin
            push = 1'b1;
          end
        end
        S_EXT: begin
          state_nx = S_IDLE;
          if (rx_data == 8'hF0) begin
            state_nx = S_EXT_BRK;
          end else if (is_plain) begin
            push      = 1'b1;
            push_data = {2'b10, rx_data};
          end
        end
        S_BRK: begin
          state_nx = S_IDLE;
          if (is_plain) begin
            push      = 1'b1;
            push_data = {2'b01, rx_data};
          end
        end
        S_EXT_BRK: begin
          state_nx = S_IDLE;
          if (is_plain) begin
            push      = 1'b1;
            push_data = {2'b11, rx_data};
          end
        end
        S_PAUSE_SKIP: begin
          // Pause bytes are fixed, so only their count matters.
          skip_nx = skip - 3'd1;
          if (skip == 3'd1) begin
            state_nx  = S_IDLE;
            push      = 1'b1;
            push_data = {2'b10, 8'h77};
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (state == S_IDLE && !rx_active) begin
      wd_nx = '0;
    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_nx = S_IDLE;
      wd_nx    = '0;
      skip_nx  = '0;
      abort_nx = rx_active;
    end else begin
      wd_nx = wd + 1'b1;
    end
  end

  // Sequencer, watchdog and abort pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip     <= '0;
      wd       <= '0;
      rx_abort <= 1'b0;
    end else begin
      state    <= state_nx;
      skip     <= skip_nx;
      wd       <= wd_nx;
      rx_abort <= abort_nx;
    end
  end

  // FIFO control: next count and the head entry the outputs will show next.
  always_comb begin
    pop      = key_valid && key_ready;
    full     = (count == CNT_W'(FIFO_DEPTH));
    do_push  = push && (!full || pop);
    drop     = push && full && !pop;
    rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nx = count;
    if (do_push && !pop) begin
      count_nx = count + 1'b1;
    end else if (!do_push && pop) begin
      count_nx = count - 1'b1;
    end
    head_nx = '0;
    if (count_nx != '0) begin
      // When nothing older remains, the entry being pushed becomes the head.
      if ((count == '0) || (pop && count == CNT_W'(1))) begin
        head_nx = push_data;
      end else begin
        head_nx = mem[rd_next];
      end
    end
  end

  // FIFO storage; data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, sticky overflow and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      key_valid    <= 1'b0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_code     <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_next;
      count     <= count_nx;
      overflow  <= overflow | drop;
      key_valid <= (count_nx != '0);
      {key_extended, key_released, key_code} <= head_nx;
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed scan-code sequences plus random byte
// streams, checked against a sequence-level reference model and scoreboard.
module tb_ps2_key_sequencer;

  localparam int T = 40;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strb = 1'b0;
  logic       rx_active = 1'b0;
  logic       rx_abort;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strb = -1000;
  bit exp_ovf = 1'b0;
  bit abort_ok = 1'b0;
  bit rand_ready = 1'b0;

  logic [9:0] exp_q[$];
  logic [7:0] seq_q[$];

  ps2_key_sequencer #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_strb(rx_strb),
    .rx_active(rx_active), .rx_abort(rx_abort), .key_code(key_code),
    .key_extended(key_extended), .key_released(key_released),
    .key_valid(key_valid), .key_ready(key_ready), .overflow(overflow)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  function automatic bit is_discard(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference FIFO: an event is lost only if the queue is full and nothing
  // leaves it in the same cycle.
  task automatic model_push(input logic [9:0] ev);
    if (exp_q.size() >= D && !key_ready) exp_ovf = 1'b1;
    else exp_q.push_back(ev);
  endtask

  // Reference decoder: keeps the pending prefix bytes as a list and decides
  // on each new byte what that list plus the byte means.
  task automatic model_byte(input logic [7:0] b);
    if (seq_q.size() != 0 && (cyc - last_strb) > T) seq_q.delete();
    last_strb = cyc;
    if (seq_q.size() == 0) begin
      if (is_prefix(b)) seq_q.push_back(b);
      else if (!is_discard(b)) model_push({2'b00, b});
    end else if (seq_q[0] == 8'hE1) begin
      seq_q.push_back(b);
      if (seq_q.size() == 8) begin
        model_push({2'b10, 8'h77});
        seq_q.delete();
      end
    end else if (b == 8'hF0 && seq_q.size() == 1 && seq_q[0] == 8'hE0) begin
      seq_q.push_back(b);
    end else begin
      if (!is_prefix(b) && !is_discard(b))
        model_push({seq_q[0] == 8'hE0, seq_q[seq_q.size()-1] == 8'hF0, b});
      seq_q.delete();
    end
  endtask

  // Drivers: all inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_strb = 1'b1;
    model_byte(b);
    tick();
    rx_strb = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_strb = 1'b0;
    rx_active = 1'b0;
    exp_q.delete();
    seq_q.delete();
    exp_ovf = 1'b0;
    idle(3);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted event.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=%0h required=none",
                   {key_extended, key_released, key_code});
        end else begin
          check("event", {22'd0, key_extended, key_released, key_code}, {22'd0, exp_q.pop_front()});
        end
      end
      if (rx_abort && !abort_ok) begin
        checks++;
        errors++;
        $display("FAIL spurious_abort actual=1 required=0");
      end
    end
  end

  // Global time limit.
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL time_limit actual=expired required=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus sequence.
  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] ovf_seq [5];
    logic [7:0] disc_tab [7];
    int first_abort;
    int n_abort;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ovf_seq   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    disc_tab  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    do_reset();
    check("reset_valid", 32'(key_valid), 32'd0);
    check("reset_code", {22'd0, key_extended, key_released, key_code}, 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_abort", 32'(rx_abort), 32'd0);

    // Make and break of one key, with the one-cycle latency.
    key_ready = 1'b0;
    check("valid_before_make", 32'(key_valid), 32'd0);
    send_byte(8'h1C);
    check("latency_make", 32'(key_valid), 32'd1);
    key_ready = 1'b1;
    idle(3);
    send_byte(8'hF0);
    check("valid_mid_break", 32'(key_valid), 32'd0);
    send_byte(8'h1C);
    check("latency_break", 32'(key_valid), 32'd1);
    idle(3);

    // Extended make and extended break.
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(3);

    // Pause: one event, only after the eighth byte.
    for (int i = 0; i < 7; i++) send_byte(pause_seq[i]);
    check("pause_no_early", 32'(key_valid), 32'd0);
    send_byte(pause_seq[7]);
    check("pause_emitted", 32'(key_valid), 32'd1);
    idle(3);

    // Stale break prefix is dropped silently; next byte is a plain make.
    send_byte(8'hF0);
    idle(T + 5);
    send_byte(8'h1C);
    idle(3);

    // Stalled receiver frame: one abort pulse at count T-1.
    abort_ok = 1'b1;
    rx_active = 1'b1;
    first_abort = -1;
    n_abort = 0;
    for (int i = 0; i < T + 5; i++) begin
      tick();
      if (rx_abort) begin
        n_abort++;
        if (first_abort < 0) first_abort = i;
      end
    end
    check("abort_cycle", 32'(first_abort), 32'(T - 1));
    check("abort_pulses", 32'(n_abort), 32'd1);
    rx_active = 1'b0;
    idle(2);
    abort_ok = 1'b0;

    // Reset in the middle of an extended sequence.
    send_byte(8'hE0);
    do_reset();
    key_ready = 1'b1;
    send_byte(8'h1C);
    idle(3);

    // Overflow with the consumer stalled, then push and pop while full.
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(ovf_seq[i]);
      idle(1);
    end
    idle(2);
    check("overflow_set", 32'(overflow), 32'(exp_ovf));
    check("head_held", 32'(key_code), 32'h15);
    key_ready = 1'b1;
    send_byte(8'h3C);
    key_ready = 1'b0;
    idle(2);
    check("head_after_pushpop", 32'(key_code), 32'h1D);
    key_ready = 1'b1;
    idle(8);
    check("drain_overflow", 32'(exp_q.size()), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Random byte streams with random consumer stalls.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = 8'hE1;
      else if (r == 4) b = disc_tab[$urandom_range(0, 6)];
      else b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) idle(T - 2 + $urandom_range(0, 3));
      else idle($urandom_range(0, 2));
      send_byte(b);
    end
    rand_ready = 1'b0;
    key_ready = 1'b1;
    idle(12);
    check("drain_random", 32'(exp_q.size()), 32'd0);
    check("overflow_random", 32'(overflow), 32'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
